// File: rtl/bit_serial_adder_if.sv
// -----------------------------------------------------------------------------
// bit_serial_adder_if
//   Handshake bundle for the bit-serial adder.
//
//   Operand side : in_valid / in_ready, op_a, op_b, cin
//   Result side  : out_valid / out_ready, sum, cout
//   Status       : busy
//   Optional     : ovf (present only when BIT_SERIAL_ADDER_OVF_EN is defined)
//
//   modport master : the environment (drives operands, accepts results)
//   modport slave  : the adder itself
// -----------------------------------------------------------------------------
interface bit_serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;
`ifdef BIT_SERIAL_ADDER_OVF_EN
    logic             ovf;
`endif

    modport master (
        output in_valid, op_a, op_b, cin, out_ready,
`ifdef BIT_SERIAL_ADDER_OVF_EN
        input  ovf,
`endif
        input  in_ready, out_valid, sum, cout, busy
    );

    modport slave (
        input  in_valid, op_a, op_b, cin, out_ready,
`ifdef BIT_SERIAL_ADDER_OVF_EN
        output ovf,
`endif
        output in_ready, out_valid, sum, cout, busy
    );
endinterface

// File: rtl/bit_serial_adder.sv
// -----------------------------------------------------------------------------
// bit_serial_adder
//   Adds two WIDTH-bit operands plus a carry-in one bit per clock, LSB first,
//   through a single fulladder cell with a registered carry. The assembled
//   sum and carry-out are returned over a valid/ready handshake.
//
//   Ports:
//     clk    : single clock, rising edge
//     rst_n  : asynchronous, active-low reset
//     bus    : bit_serial_adder_if.slave
//              in_valid/in_ready/op_a/op_b/cin   operand handshake
//              out_valid/out_ready/sum/cout      result handshake
//              busy                              high in RUN or DONE
//              ovf                               signed overflow (optional)
//
//   Optional feature macro: BIT_SERIAL_ADDER_OVF_EN
//     When defined, a registered two's-complement overflow flag (ovf) is
//     produced alongside the sum. When undefined, no ovf flop exists.
//
//   Timing: operands accepted on edge 0 give out_valid=1 after edge WIDTH.
// -----------------------------------------------------------------------------

// Single-bit full adder cell driven by the serial datapath.
module fulladder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic carry
);
    assign sum   = a ^ b ^ cin;
    assign carry = (a & b) | (cin & (a ^ b));
endmodule

module bit_serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    bit_serial_adder_if.slave   bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic [WIDTH-1:0] sum_sh_next;
    logic             carry_q;
    logic [CNT_W-1:0] cnt;
    logic             last_bit;

    logic             fa_sum;
    logic             fa_carry;

    fulladder fa (
        .a     (a_sh[0]),
        .b     (b_sh[0]),
        .cin   (carry_q),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    // The new sum bit enters at the MSB so that after WIDTH shifts bit 0 of
    // the operands has landed in bit 0 of the result.
    generate
        if (WIDTH == 1) begin : g_sum_w1
            assign sum_sh_next = fa_sum;
        end else begin : g_sum_wn
            assign sum_sh_next = {fa_sum, sum_sh[WIDTH-1:1]};
        end
    endgenerate

    assign last_bit     = (cnt == CNT_W'(WIDTH - 1));
    assign bus.in_ready = (state == IDLE);
    assign bus.busy     = (state != IDLE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking (<=) so every flop
            // samples pre-edge values regardless of statement order.
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default assignment first keeps this block free of latches
        // on any path that does not explicitly assign state_next.
        state_next = state;
        unique case (state)
            IDLE:    if (bus.in_valid)  state_next = RUN;
            RUN:     if (last_bit)      state_next = DONE;
            DONE:    if (bus.out_ready) state_next = IDLE;
            default:                    state_next = IDLE;
        endcase
    end

    // Serial datapath and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh          <= '0;
            b_sh          <= '0;
            sum_sh        <= '0;
            carry_q       <= 1'b0;
            cnt           <= '0;
            bus.sum       <= '0;
            bus.cout      <= 1'b0;
            bus.out_valid <= 1'b0;
`ifdef BIT_SERIAL_ADDER_OVF_EN
            bus.ovf       <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_sh    <= bus.op_a;
                        b_sh    <= bus.op_b;
                        carry_q <= bus.cin;
                        sum_sh  <= '0;
                        cnt     <= '0;
                    end
                end
                RUN: begin
                    sum_sh  <= sum_sh_next;
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    carry_q <= fa_carry;
                    cnt     <= cnt + 1'b1;
                    if (last_bit) begin
                        bus.sum       <= sum_sh_next;
                        bus.cout      <= fa_carry;
                        bus.out_valid <= 1'b1;
`ifdef BIT_SERIAL_ADDER_OVF_EN
                        // Carry into the MSB differs from carry out of it.
                        bus.ovf       <= carry_q ^ fa_carry;
`endif
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_bit_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_bit_serial_adder
//   Self-checking bench for bit_serial_adder (WIDTH=8). Directed cases,
//   backpressure, asynchronous reset mid-job and 20 random jobs are compared
//   against an arithmetic reference model. Define BIT_SERIAL_ADDER_OVF_EN to
//   also check the signed-overflow flag.
// -----------------------------------------------------------------------------
module tb_bit_serial_adder;
    localparam int WIDTH = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    bit_serial_adder_if #(.WIDTH(WIDTH)) bus ();

    bit_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Expected results: {ovf, cout, sum}
    logic [9:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer addition; carry-out is bit WIDTH of the total.
    function automatic logic [8:0] ref_add(input logic [7:0] a, input logic [7:0] b, input logic c);
        int unsigned total;
        total = int'(a) + int'(b) + int'(c);
        return total[8:0];
    endfunction

    // Reference: signed overflow when the true signed sum leaves [-128, 127].
    function automatic logic ref_ovf(input logic [7:0] a, input logic [7:0] b, input logic c);
        int s;
        s = int'($signed(a)) + int'($signed(b)) + int'(c);
        return (s > 127) || (s < -128);
    endfunction

    // Present operands and hold them until the adder accepts.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic c);
        int n;
        @(negedge clk);
        bus.op_a     = a;
        bus.op_b     = b;
        bus.cin      = c;
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept_timeout", 64'(n < 50), 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        // Operands need not be held after acceptance.
        bus.op_a     = 8'($urandom);
        bus.op_b     = 8'($urandom);
        bus.cin      = 1'($urandom);
    endtask

    // Count rising edges after acceptance until out_valid, bounded.
    task automatic wait_out(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    // Accept the result after an optional delay and confirm it retires once.
    task automatic take(input int delay);
        repeat (delay) @(negedge clk);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("handshake_clear", 64'(bus.out_valid), 64'd0);
        check("handshake_idle", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic run_job(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic c, input logic [7:0] exp_sum, input logic exp_cout);
        int lat;
        send(a, b, c);
        wait_out(lat);
        check({tag, "_lat"}, 64'(lat), 64'(WIDTH));
        check({tag, "_sum"}, 64'(bus.sum), 64'(exp_sum));
        check({tag, "_cout"}, 64'(bus.cout), 64'(exp_cout));
`ifdef BIT_SERIAL_ADDER_OVF_EN
        check({tag, "_ovf"}, 64'(bus.ovf), 64'(ref_ovf(a, b, c)));
`endif
        take(0);
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rc;
        logic [8:0] r;
        logic [9:0] e;
        logic [7:0] held_sum;
        logic       held_cout;
        int         lat;
        int         results;
        bit         early;

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.cin       = 1'b0;

        // Reset state.
        #2;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_sum", 64'(bus.sum), 64'd0);
        check("rst_cout", 64'(bus.cout), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
`ifdef BIT_SERIAL_ADDER_OVF_EN
        check("rst_ovf", 64'(bus.ovf), 64'd0);
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed arithmetic cases.
        run_job("t1", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
        run_job("t2a", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);

        // Backpressure on 0xFF+0xFF+1.
        send(8'hFF, 8'hFF, 1'b1);
        wait_out(lat);
        check("bp_lat", 64'(lat), 64'(WIDTH));
        check("bp_sum", 64'(bus.sum), 64'hFF);
        check("bp_cout", 64'(bus.cout), 64'd1);
        held_sum  = bus.sum;
        held_cout = bus.cout;
        repeat (5) begin
            @(negedge clk);
            check("bp_hold_sum", 64'(bus.sum), 64'(held_sum));
            check("bp_hold_cout", 64'(bus.cout), 64'(held_cout));
            check("bp_hold_valid", 64'(bus.out_valid), 64'd1);
            check("bp_in_ready", 64'(bus.in_ready), 64'd0);
            check("bp_busy", 64'(bus.busy), 64'd1);
        end
        take(0);
        check("bp_busy_after", 64'(bus.busy), 64'd0);

        // Asynchronous reset with cnt=3 in RUN; last result (0xFF, cout=1) is
        // still on the outputs and must clear at once.
        send(8'hAA, 8'h55, 1'b1);
        repeat (3) @(posedge clk);
        #2;
        check("mid_busy_before", 64'(bus.busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(bus.out_valid), 64'd0);
        check("mid_rst_sum", 64'(bus.sum), 64'd0);
        check("mid_rst_cout", 64'(bus.cout), 64'd0);
        check("mid_rst_busy", 64'(bus.busy), 64'd0);
        check("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            check("mid_no_partial", 64'(bus.out_valid), 64'd0);
        end
        run_job("post_rst", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0);

`ifdef BIT_SERIAL_ADDER_OVF_EN
        run_job("ovf1", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0);
        check("ovf1_flag", 64'(bus.ovf), 64'd1);
        run_job("ovf2", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1);
        check("ovf2_flag", 64'(bus.ovf), 64'd1);
        run_job("ovf3", 8'h80, 8'h7F, 1'b0, 8'hFF, 1'b0);
        check("ovf3_flag", 64'(bus.ovf), 64'd0);
`endif

        // Random jobs with random gaps and early/late out_ready.
        results = 0;
        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom_range(0, 1));
            r  = ref_add(ra, rb, rc);
            exp_q.push_back({ref_ovf(ra, rb, rc), r});
            send(ra, rb, rc);
            early = 1'($urandom_range(0, 1));
            if (early) bus.out_ready = 1'b1;
            wait_out(lat);
            check("rand_lat", 64'(lat), 64'(WIDTH));
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("rand_sum", 64'(bus.sum), 64'(e[7:0]));
                check("rand_cout", 64'(bus.cout), 64'(e[8]));
`ifdef BIT_SERIAL_ADDER_OVF_EN
                check("rand_ovf", 64'(bus.ovf), 64'(e[9]));
`endif
            end
            if (early) begin
                @(posedge clk);
                #1;
                check("rand_early_clear", 64'(bus.out_valid), 64'd0);
                @(negedge clk);
                bus.out_ready = 1'b0;
            end else begin
                take($urandom_range(0, 4));
            end
            results++;
        end
        check("rand_results", 64'(results), 64'd20);
        check("rand_queue_empty", 64'(exp_q.size()), 64'd0);
        repeat (WIDTH + 4) @(negedge clk);
        check("rand_no_dup", 64'(bus.out_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
